// File: rtl/collatz_pkg.sv
// Shared types and default sizes for the Collatz sweep controller and its best-value tracker.
package collatz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RUN,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_MAX_STEPS = 1000;

endpackage

// File: rtl/collatz_best_tracker.sv
// Keeps the start value with the longest trajectory seen in the current sweep.
module collatz_best_tracker import collatz_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             update,
  input  logic [WIDTH-1:0] n,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] best_n,
  output logic [CNT_W-1:0] best_steps
);

  logic [WIDTH-1:0] r_bestN;
  logic [CNT_W-1:0] r_bestSteps;
  logic             r_first;
  logic             w_take;

  // Strict greater-than keeps the smaller n on ties, since values arrive in increasing order.
  assign w_take = r_first || (steps > r_bestSteps);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bestN     <= '0;
      r_bestSteps <= '0;
      r_first     <= 1'b1;
    end else if (clear) begin
      r_bestN     <= '0;
      r_bestSteps <= '0;
      r_first     <= 1'b1;
    end else if (update) begin
      if (w_take) begin
        r_bestN     <= n;
        r_bestSteps <= steps;
      end
      r_first <= 1'b0;
    end
  end

  assign best_n     = r_bestN;
  assign best_steps = r_bestSteps;

endmodule

// File: rtl/collatz_sweep.sv
// Sweep controller: runs the iterate-until-one engine over an inclusive range and reports the longest trajectory.
module collatz_sweep import collatz_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_n,
  input  logic [WIDTH-1:0] end_n,
  output logic             busy,
  output logic             finished,
  output logic             timeout,
  output logic [WIDTH-1:0] cur_n,
  output logic [WIDTH-1:0] best_n,
  output logic [CNT_W-1:0] best_steps,
  output logic             it_go,
  output logic [WIDTH-1:0] it_n,
  input  logic [WIDTH-1:0] it_dout,
  input  logic             it_done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [WIDTH-1:0] ONE_N   = WIDTH'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_curN;
  logic [WIDTH-1:0] r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_steps;
  logic             r_timeout;
  logic [WIDTH-1:0] w_lo;
  logic             w_empty;
  logic             w_accept;
  logic             w_clearBest;
  logic             w_update;
  logic             w_itGo;

  // Zero is not a valid Collatz start, so the range is clamped to begin at 1.
  assign w_lo    = (start_n == '0) ? ONE_N : start_n;
  assign w_empty = (w_lo > end_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_clearBest = 1'b0;
    w_update    = 1'b0;
    w_itGo      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_clearBest = 1'b1;
          w_nextState = w_empty ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_itGo      = 1'b1;
        w_nextState = ST_WAIT;
      end
      // The engine never raises done for n = 1, so that case skips RUN entirely.
      ST_WAIT: begin
        w_nextState = (it_dout == ONE_N) ? ST_UPDATE : ST_RUN;
      end
      ST_RUN: begin
        if (it_done || (r_cnt == MAX_CNT)) begin
          w_nextState = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_update    = 1'b1;
        w_nextState = (r_curN == r_hi) ? ST_DONE : ST_LOAD;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_curN    <= '0;
      r_hi      <= '0;
      r_cnt     <= '0;
      r_steps   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_hi      <= end_n;
            r_timeout <= 1'b0;
            if (!w_empty) begin
              r_curN <= w_lo;
            end
          end
        end
        ST_WAIT: begin
          if (it_dout == ONE_N) begin
            r_steps <= '0;
          end else begin
            r_cnt <= CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (it_done) begin
            r_steps <= r_cnt;
          end else if (r_cnt == MAX_CNT) begin
            r_steps   <= MAX_CNT;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Compare before incrementing so an all-ones upper bound cannot wrap.
        ST_UPDATE: begin
          if (r_curN != r_hi) begin
            r_curN <= r_curN + ONE_N;
          end
        end
        default: begin
        end
      endcase
    end
  end

  collatz_best_tracker #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bestTracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (w_clearBest),
    .update    (w_update),
    .n         (r_curN),
    .steps     (r_steps),
    .best_n    (best_n),
    .best_steps(best_steps)
  );

  assign busy     = (r_state == ST_LOAD) || (r_state == ST_WAIT) ||
                    (r_state == ST_RUN)  || (r_state == ST_UPDATE);
  assign finished = (r_state == ST_DONE);
  assign timeout  = r_timeout;
  assign cur_n    = r_curN;
  assign it_go    = w_itGo;
  assign it_n     = r_curN;

endmodule

// File: tb/tb_collatz_sweep.sv
// Directed bench: dutA drives a reference Collatz engine, dutB a stub engine that never finishes (MAX_STEPS = 5).
module tb_collatz_sweep;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        aStart = 1'b0;
  logic [31:0] aStartN = '0;
  logic [31:0] aEndN = '0;
  logic        aBusy, aFinished, aTimeout, aItGo;
  logic [31:0] aCurN, aBestN, aItN;
  logic [15:0] aBestSteps;
  logic [31:0] aDout = '0;
  logic        aDone = 1'b0;

  logic        bStart = 1'b0;
  logic [31:0] bStartN = '0;
  logic [31:0] bEndN = '0;
  logic        bBusy, bFinished, bTimeout, bItGo;
  logic [31:0] bCurN, bBestN, bItN;
  logic [15:0] bBestSteps;
  logic [31:0] bDout = '0;
  logic        bDone;

  int checkCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  collatz_sweep #(.WIDTH(32), .CNT_W(16), .MAX_STEPS(1000)) dutA (
    .clk(clk), .reset_n(reset_n), .start(aStart), .start_n(aStartN), .end_n(aEndN),
    .busy(aBusy), .finished(aFinished), .timeout(aTimeout), .cur_n(aCurN),
    .best_n(aBestN), .best_steps(aBestSteps), .it_go(aItGo), .it_n(aItN),
    .it_dout(aDout), .it_done(aDone)
  );

  collatz_sweep #(.WIDTH(32), .CNT_W(16), .MAX_STEPS(5)) dutB (
    .clk(clk), .reset_n(reset_n), .start(bStart), .start_n(bStartN), .end_n(bEndN),
    .busy(bBusy), .finished(bFinished), .timeout(bTimeout), .cur_n(bCurN),
    .best_n(bBestN), .best_steps(bBestSteps), .it_go(bItGo), .it_n(bItN),
    .it_dout(bDout), .it_done(bDone)
  );

  function automatic logic [31:0] collatzNext(input logic [31:0] v);
    return v[0] ? (v * 32'd3 + 32'd1) : (v >> 1);
  endfunction

  // Reference engine: registered done rises on the same edge that dout becomes 1.
  always @(posedge clk) begin
    if (aItGo) begin
      aDout <= aItN;
      aDone <= 1'b0;
    end else if (!aDone && aDout != 32'd1) begin
      aDout <= collatzNext(aDout);
      aDone <= (collatzNext(aDout) == 32'd1);
    end
  end

  // Stub engine: holds the loaded value and never reports done.
  assign bDone = 1'b0;
  always @(posedge clk) begin
    if (bItGo) bDout <= bItN;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit selB, input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    if (selB) begin
      bStart = 1'b1; bStartN = s; bEndN = e;
    end else begin
      aStart = 1'b1; aStartN = s; aEndN = e;
    end
    @(negedge clk);
    aStart = 1'b0;
    bStart = 1'b0;
  endtask

  task automatic waitDone(input bit selB, input int limit, output int busyCyc, output int goCyc, output int waited);
    busyCyc = 0;
    goCyc = 0;
    waited = 0;
    while (!(selB ? bFinished : aFinished) && waited < limit) begin
      busyCyc += int'(selB ? bBusy : aBusy);
      goCyc += int'(selB ? bItGo : aItGo);
      waited++;
      @(negedge clk);
    end
    checkOutput("done_wait", {63'd0, (selB ? bFinished : aFinished)}, 64'd1);
  endtask

  initial begin
    int busyCyc, goCyc, waited;

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", aBusy, 0);
    checkOutput("rst_finished", aFinished, 0);
    checkOutput("rst_timeout", aTimeout, 0);
    checkOutput("rst_it_go", aItGo, 0);
    checkOutput("rst_cur_n", aCurN, 0);
    checkOutput("rst_it_n", aItN, 0);
    checkOutput("rst_best_n", aBestN, 0);
    checkOutput("rst_best_steps", aBestSteps, 0);
    reset_n = 1'b1;

    $display("[TB] sweep 1..10");
    applyStimulus(1'b0, 32'd1, 32'd10);
    waitDone(1'b0, 500, busyCyc, goCyc, waited);
    checkOutput("r10_busy_cycles", busyCyc, 97);
    checkOutput("r10_go_cycles", goCyc, 10);
    checkOutput("r10_best_n", aBestN, 9);
    checkOutput("r10_best_steps", aBestSteps, 19);
    checkOutput("r10_timeout", aTimeout, 0);
    checkOutput("r10_busy_done", aBusy, 0);

    $display("[TB] sweep 27..27");
    applyStimulus(1'b0, 32'd27, 32'd27);
    waitDone(1'b0, 500, busyCyc, goCyc, waited);
    checkOutput("r27_best_n", aBestN, 27);
    checkOutput("r27_best_steps", aBestSteps, 111);
    checkOutput("r27_go_cycles", goCyc, 1);
    checkOutput("r27_busy_cycles", busyCyc, 114);

    $display("[TB] sweep 1..1");
    applyStimulus(1'b0, 32'd1, 32'd1);
    waitDone(1'b0, 50, busyCyc, goCyc, waited);
    checkOutput("r1_busy_cycles", busyCyc, 3);
    checkOutput("r1_best_n", aBestN, 1);
    checkOutput("r1_best_steps", aBestSteps, 0);

    $display("[TB] empty sweep 0..0");
    applyStimulus(1'b0, 32'd0, 32'd0);
    waitDone(1'b0, 50, busyCyc, goCyc, waited);
    checkOutput("r0_wait_cycles", waited, 0);
    checkOutput("r0_best_n", aBestN, 0);
    checkOutput("r0_best_steps", aBestSteps, 0);

    $display("[TB] sweep at top of range");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(1'b0, 1100, busyCyc, goCyc, waited);
    checkOutput("top_best_n", aBestN, 64'hFFFF_FFFF);
    checkOutput("top_cur_n", aCurN, 64'hFFFF_FFFF);
    checkOutput("top_go_cycles", goCyc, 1);

    $display("[TB] start while busy is ignored");
    applyStimulus(1'b0, 32'd1, 32'd10);
    repeat (10) @(negedge clk);
    checkOutput("ign_busy", aBusy, 1);
    aStart = 1'b1; aStartN = 32'd27; aEndN = 32'd27;
    @(negedge clk);
    aStart = 1'b0;
    waitDone(1'b0, 500, busyCyc, goCyc, waited);
    checkOutput("ign_best_n", aBestN, 9);
    checkOutput("ign_best_steps", aBestSteps, 19);

    $display("[TB] stub engine timeout 4..5");
    applyStimulus(1'b1, 32'd4, 32'd5);
    waitDone(1'b1, 200, busyCyc, goCyc, waited);
    checkOutput("tmo_flag", bTimeout, 1);
    checkOutput("tmo_best_n", bBestN, 4);
    checkOutput("tmo_best_steps", bBestSteps, 5);
    checkOutput("tmo_busy_cycles", busyCyc, 16);

    applyStimulus(1'b1, 32'd1, 32'd1);
    checkOutput("tmo_cleared", bTimeout, 0);
    waitDone(1'b1, 50, busyCyc, goCyc, waited);
    checkOutput("tmo_after", bTimeout, 0);
    checkOutput("tmo_new_best_n", bBestN, 1);

    $display("[TB] reset during RUN of 1..100");
    applyStimulus(1'b0, 32'd1, 32'd100);
    waited = 0;
    while (aCurN !== 32'd27 && waited < 3000) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("mid_reached_27", aCurN, 27);
    repeat (10) @(negedge clk);
    checkOutput("mid_pre_busy", aBusy, 1);
    checkOutput("mid_pre_best_n", aBestN, 25);
    checkOutput("mid_pre_best_steps", aBestSteps, 23);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_it_go", aItGo, 0);
    checkOutput("mid_busy", aBusy, 0);
    checkOutput("mid_best_n", aBestN, 0);
    checkOutput("mid_best_steps", aBestSteps, 0);
    checkOutput("mid_cur_n", aCurN, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'd6, 32'd6);
    waitDone(1'b0, 100, busyCyc, goCyc, waited);
    checkOutput("r6_best_n", aBestN, 6);
    checkOutput("r6_best_steps", aBestSteps, 8);
    checkOutput("r6_busy_cycles", busyCyc, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
